// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and FSM state encodings for the MIPS boot loader.
//   ADDR_W  memory word-address width
//   WORD_W  memory data width
//   DEPTH   number of memory words (maximum legal program length)
package mips_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEPTH  = 128;

  typedef logic [2:0] state_t;

  localparam state_t HDR   = 3'd0;
  localparam state_t DATA  = 3'd1;
  localparam state_t WRITE = 3'd2;
  localparam state_t CSUM  = 3'd3;
  localparam state_t RUN   = 3'd4;
  localparam state_t ERR_S = 3'd5;

endpackage

// File: rtl/mips_boot_loader_word_assembler.sv
// word_assembler: packs a serial byte stream into big-endian 32-bit words.
//   CLK, RST     clock, synchronous active-high reset
//   CLR          discard any partially assembled word
//   RX_DATA      incoming byte
//   RX_VALID     RX_DATA valid this cycle
//   WORD         completed word (valid only with WORD_VALID)
//   WORD_VALID   high in the cycle the 4th byte of a word arrives
module word_assembler
  import mips_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic [WORD_W-1:0] WORD,
  output logic              WORD_VALID
);

  logic [1:0]  idx_q;
  logic [23:0] acc_q;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (RX_VALID) begin
      idx_q <= idx_q + 2'd1;
      acc_q <= {acc_q[15:0], RX_DATA};
    end
  end

  // The final byte is taken straight from the input so the word completes in
  // the same cycle it arrives, giving the loader a one-cycle write latency.
  assign WORD       = {acc_q, RX_DATA};
  assign WORD_VALID = RX_VALID && (idx_q == 2'd3);

endmodule

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: holds the core in reset, loads a program from a serial
// byte stream into memory starting at address 0, then releases the core and
// hands it the memory bus. LOAD restarts loading at any time.
// Stream: header word (N in [7:0], upper bits zero), then N data words,
// big-endian. With CHECKSUM_EN defined, a trailer word equal to the 32-bit
// sum of the data words follows; without it no trailer is expected.
//   CLK, RST        clock, synchronous active-high reset
//   LOAD            reload request pulse
//   RX_DATA/VALID   host byte stream
//   CPU_CS/WE/ADDR  core memory strobes and address (forwarded in RUN)
//   CPU_RST         core reset (high unless running)
//   MEM_CS/WE/ADDR  memory strobes and address
//   LD_DATA/LD_DOE  loader write data and its bus-drive enable
//   BUSY, ERR       loading in progress, load failed
//   WORDS_LOADED    data words written during this load
module mips_boot_loader
  import mips_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  input  logic              CPU_CS,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic              CPU_RST,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0] LD_DATA,
  output logic              LD_DOE,
  output logic              BUSY,
  output logic              ERR,
  output logic [7:0]        WORDS_LOADED
);

  state_t              state_q, state_d;
  logic [7:0]          n_q, n_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                rx_en;
  logic [WORD_W-1:0]   word;
  logic                word_valid;
`ifdef CHECKSUM_EN
  logic [WORD_W-1:0]   sum_q, sum_d;
`endif

  assign rx_en = RX_VALID && (state_q != RUN) && (state_q != ERR_S);

  word_assembler u_asm (
    .CLK        (CLK),
    .RST        (RST),
    .CLR        (LOAD),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (rx_en),
    .WORD       (word),
    .WORD_VALID (word_valid)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      HDR: if (word_valid) begin
        if (word[7:0] == 8'd0) begin
`ifdef CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = RUN;
`endif
        end else if (word[31:8] != '0 || word[7:0] > 8'(DEPTH)) begin
          state_d = ERR_S;
        end else begin
          n_d     = word[7:0];
          state_d = DATA;
        end
      end
      DATA: if (word_valid) begin
        data_d  = word;
`ifdef CHECKSUM_EN
        sum_d   = sum_q + word;
`endif
        state_d = WRITE;
      end
      WRITE: begin
        widx_d = widx_q + 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q + 8'd1 == n_q) begin
`ifdef CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = RUN;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef CHECKSUM_EN
      CSUM: if (word_valid) state_d = (word == sum_q) ? RUN : ERR_S;
`endif
      default: ;
    endcase
    // The write output of the WRITE cycle is combinational, so a LOAD landing
    // there still completes that write before the restart takes effect.
    if (LOAD) begin
      state_d = HDR;
      widx_d  = '0;
      cnt_d   = '0;
`ifdef CHECKSUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HDR;
      n_q     <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    MEM_CS   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    if (state_q == RUN) begin
      MEM_CS   = CPU_CS;
      MEM_WE   = CPU_WE;
      MEM_ADDR = CPU_ADDR;
    end else if (state_q == WRITE) begin
      MEM_CS   = 1'b1;
      MEM_WE   = 1'b1;
      MEM_ADDR = widx_q;
    end
  end

  assign LD_DOE       = (state_q == WRITE);
  assign LD_DATA      = data_q;
  assign CPU_RST      = (state_q != RUN);
  assign BUSY         = (state_q != RUN) && (state_q != ERR_S);
  assign ERR          = (state_q == ERR_S);
  assign WORDS_LOADED = cnt_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader. Inputs change 1 time unit after the
// rising edge; loader writes are captured on the falling edge into a memory
// model. Define CHECKSUM_EN for both bench and RTL to exercise the trailer.
module tb_mips_boot_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic        CPU_CS = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [6:0]  CPU_ADDR = '0;
  logic        CPU_RST;
  logic        MEM_CS;
  logic        MEM_WE;
  logic [6:0]  MEM_ADDR;
  logic [31:0] LD_DATA;
  logic        LD_DOE;
  logic        BUSY;
  logic        ERR;
  logic [7:0]  WORDS_LOADED;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int wr_base;
  logic [31:0] mem [128];

  mips_boot_loader dut (
    .CLK          (CLK),
    .RST          (RST),
    .LOAD         (LOAD),
    .RX_DATA      (RX_DATA),
    .RX_VALID     (RX_VALID),
    .CPU_CS       (CPU_CS),
    .CPU_WE       (CPU_WE),
    .CPU_ADDR     (CPU_ADDR),
    .CPU_RST      (CPU_RST),
    .MEM_CS       (MEM_CS),
    .MEM_WE       (MEM_WE),
    .MEM_ADDR     (MEM_ADDR),
    .LD_DATA      (LD_DATA),
    .LD_DOE       (LD_DOE),
    .BUSY         (BUSY),
    .ERR          (ERR),
    .WORDS_LOADED (WORDS_LOADED)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (MEM_CS && MEM_WE && LD_DOE) begin
      mem[MEM_ADDR] = LD_DATA;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_load();
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
  endtask

  initial begin
    for (int unsigned i = 0; i < 128; i++) mem[i] = 32'hA5A5_A5A5;
    repeat (3) tick();
    RST = 1'b0;

    check("rst_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    check("rst_busy",    {31'd0, BUSY},    32'd1);
    check("rst_err",     {31'd0, ERR},     32'd0);
    check("rst_words",   {24'd0, WORDS_LOADED}, 32'd0);
    check("rst_doe",     {31'd0, LD_DOE},  32'd0);
    check("rst_mem_cs",  {31'd0, MEM_CS},  32'd0);
    check("rst_mem_we",  {31'd0, MEM_WE},  32'd0);

`ifndef CHECKSUM_EN
    // Two-word program with write latency check.
    send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    check("last_wr_we",   {31'd0, MEM_WE},  32'd1);
    check("last_wr_addr", {25'd0, MEM_ADDR}, 32'd1);
    check("last_wr_data", LD_DATA, 32'h1234_5678);
    check("last_wr_rst",  {31'd0, CPU_RST}, 32'd1);
    tick();
    check("run_cpu_rst",  {31'd0, CPU_RST}, 32'd0);
    check("run_busy",     {31'd0, BUSY},    32'd0);
    check("words2",       {24'd0, WORDS_LOADED}, 32'd2);
    check("mem0",         mem[0], 32'hDEAD_BEEF);
    check("mem1",         mem[1], 32'h1234_5678);
    check("wr_cnt2",      32'(wr_cnt), 32'd2);

    // Bus pass-through in RUN.
    CPU_ADDR = 7'h15; CPU_CS = 1'b1; CPU_WE = 1'b1;
    #1;
    check("pt_addr", {25'd0, MEM_ADDR}, 32'h15);
    check("pt_we",   {31'd0, MEM_WE},   32'd1);
    check("pt_cs",   {31'd0, MEM_CS},   32'd1);
    check("pt_doe",  {31'd0, LD_DOE},   32'd0);
    CPU_CS = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0;
    wr_base = wr_cnt;
    send_word(32'h0000_0001);
    send_word(32'h0BAD_0BAD);
    tick();
    check("run_ignores_rx", {31'd0, CPU_RST}, 32'd0);
    check("run_no_write",   32'(wr_cnt - wr_base), 32'd0);

    // Empty program goes straight to RUN.
    pulse_load();
    check("load_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    check("load_busy",    {31'd0, BUSY},    32'd1);
    check("load_words",   {24'd0, WORDS_LOADED}, 32'd0);
    wr_base = wr_cnt;
    send_word(32'h0000_0000);
    check("n0_cpu_rst",  {31'd0, CPU_RST}, 32'd0);
    check("n0_no_write", 32'(wr_cnt - wr_base), 32'd0);

    // Oversized header, then recovery.
    pulse_load();
    send_word(32'h0000_0081);
    check("big_err",     {31'd0, ERR},     32'd1);
    check("big_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    check("big_busy",    {31'd0, BUSY},    32'd0);
    wr_base = wr_cnt;
    send_word(32'h0000_0001);
    send_word(32'h7777_7777);
    tick();
    check("err_held",     {31'd0, ERR}, 32'd1);
    check("err_no_write", 32'(wr_cnt - wr_base), 32'd0);
    pulse_load();
    check("recover_err",  {31'd0, ERR},  32'd0);
    check("recover_busy", {31'd0, BUSY}, 32'd1);
    send_word(32'h0000_0001);
    send_word(32'hCAFE_BABE);
    tick();
    check("recover_run", {31'd0, CPU_RST}, 32'd0);
    check("recover_mem0", mem[0], 32'hCAFE_BABE);

    // Nonzero upper header bits.
    pulse_load();
    send_word(32'h0001_0002);
    check("hdr_upper_err", {31'd0, ERR}, 32'd1);

    // LOAD mid-word discards partial bytes.
    pulse_load();
    send_word(32'h0000_0003);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_load();
    check("abort_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    check("abort_busy",    {31'd0, BUSY},    32'd1);
    check("abort_words",   {24'd0, WORDS_LOADED}, 32'd0);
    wr_base = wr_cnt;
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    tick();
    check("fresh_run",   {31'd0, CPU_RST}, 32'd0);
    check("fresh_words", {24'd0, WORDS_LOADED}, 32'd1);
    check("fresh_mem0",  mem[0], 32'h0102_0304);
    check("fresh_mem1",  mem[1], 32'h1234_5678);
    check("fresh_wrcnt", 32'(wr_cnt - wr_base), 32'd1);

    // Maximum length program.
    pulse_load();
    wr_base = wr_cnt;
    send_word(32'h0000_0080);
    for (int unsigned i = 0; i < 128; i++) send_word(32'h1000_0000 + 32'(i));
    tick();
    check("max_run",    {31'd0, CPU_RST}, 32'd0);
    check("max_words",  {24'd0, WORDS_LOADED}, 32'd128);
    check("max_mem0",   mem[0],   32'h1000_0000);
    check("max_mem127", mem[127], 32'h1000_007F);
    check("max_wrcnt",  32'(wr_cnt - wr_base), 32'd128);
`else
    // Matching trailer.
    wr_base = wr_cnt;
    send_word(32'h0000_0002);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    tick();
    check("cs_wait_rst",  {31'd0, CPU_RST}, 32'd1);
    check("cs_wait_busy", {31'd0, BUSY},    32'd1);
    send_word(32'h0000_0003);
    check("cs_ok_run",   {31'd0, CPU_RST}, 32'd0);
    check("cs_ok_err",   {31'd0, ERR},     32'd0);
    check("cs_ok_mem0",  mem[0], 32'd1);
    check("cs_ok_mem1",  mem[1], 32'd2);
    check("cs_ok_wrcnt", 32'(wr_cnt - wr_base), 32'd2);

    // Mismatched trailer.
    pulse_load();
    mem[0] = 32'hA5A5_A5A5;
    mem[1] = 32'hA5A5_A5A5;
    wr_base = wr_cnt;
    send_word(32'h0000_0002);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0004);
    check("cs_bad_err",   {31'd0, ERR},     32'd1);
    check("cs_bad_rst",   {31'd0, CPU_RST}, 32'd1);
    check("cs_bad_mem0",  mem[0], 32'd1);
    check("cs_bad_mem1",  mem[1], 32'd2);
    check("cs_bad_wrcnt", 32'(wr_cnt - wr_base), 32'd2);

    // Empty program still expects a zero trailer.
    pulse_load();
    send_word(32'h0000_0000);
    check("cs_n0_busy", {31'd0, BUSY}, 32'd1);
    send_word(32'h0000_0000);
    check("cs_n0_run",  {31'd0, CPU_RST}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Boot sequencer and memory-bus owner for the single-cycle-memory MIPS core (7-bit word address, 32-bit shared data bus, CS/WE strobes).
- Holds the core in reset and receives a program as a serial byte stream from the host interface (UART RX).
- Assembles the bytes into 32-bit words and writes them sequentially into instruction/data memory from address 0.
- Then releases the core and hands the memory bus to it; a LOAD request re-enters loading at any time.

Parameters:
- ADDR_W, 7, memory word-address width
- DEPTH, 128, number of memory words; maximum legal program length

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- LOAD  in  1  one-cycle pulse; request a reload
- RX_DATA  in  8  host byte
- RX_VALID  in  1  one-cycle strobe; RX_DATA valid this cycle
- CPU_CS  in  1  core memory chip select
- CPU_WE  in  1  core memory write enable
- CPU_ADDR  in  ADDR_W  core memory address
- CPU_RST  out  1  reset to core; high while loading or in error
- MEM_CS  out  1  chip select to memory
- MEM_WE  out  1  write enable to memory
- MEM_ADDR  out  ADDR_W  address to memory
- LD_DATA  out  32  loader write data
- LD_DOE  out  1  top level drives LD_DATA onto the shared bus when high
- BUSY  out  1  loading in progress
- ERR  out  1  load failed (bad header, or checksum mismatch when CHECKSUM_EN)
- WORDS_LOADED  out  8  data words written this load

Behaviour:
- Reset values: state=HDR, CPU_RST=1, BUSY=1, ERR=0, WORDS_LOADED=0, LD_DOE=0, MEM_CS=0, MEM_WE=0, byte index=0, word index=0.
- Byte assembly:
  - Big-endian. The first byte of each word lands in [31:24].
  - A 2-bit byte index advances on every RX_VALID in HDR, DATA, WRITE and CSUM.
  - On the 4th byte, word_valid pulses for one cycle with the completed word.
  - RX_VALID is ignored in RUN and ERR; the byte index is cleared on entry to HDR.
- States:
  - HDR: on word_valid, N = word[7:0].
    - N==0 -> RUN, memory untouched.
    - N>DEPTH or word[31:8]!=0 -> ERR.
    - Otherwise latch N -> DATA.
  - DATA: on word_valid, latch the word into LD_DATA -> WRITE.
  - WRITE (exactly 1 cycle): MEM_CS=1, MEM_WE=1, LD_DOE=1, MEM_ADDR=word index.
    - Then word index++ and WORDS_LOADED++.
    - If the new count equals N -> RUN (or CSUM when enabled); else -> DATA.
    - A byte arriving during WRITE is still accepted; no word can complete in WRITE.
  - RUN: CPU_RST=0, BUSY=0. MEM_CS/MEM_WE/MEM_ADDR = CPU_* combinationally; LD_DOE=0.
  - ERR: CPU_RST=1, BUSY=0, ERR=1; held until LOAD or RST.
- Outside RUN, MEM_* are driven only by the loader (0 except in WRITE). The core is in reset, so there is no bus contention.
- CPU_RST timing: falls on the clock edge that enters RUN. It is high on every edge from reset through the last write, so the core's synchronous reset completes (pc=0, state=fetch).
- LOAD in any state -> HDR next cycle. It clears the byte index, word index, WORDS_LOADED and ERR, and asserts CPU_RST. LOAD during WRITE: the write still completes that cycle.
- LOAD and RST together: RST wins, with an identical result.
- RST or LOAD mid-load does not erase memory; already-written words remain.
- Latency: the last data byte arrives in cycle t; the write is in t+1; CPU_RST=0 from t+2.

Optional Feature:
- Macro: CHECKSUM_EN.
- With the macro:
  - A running 32-bit sum (mod 2^32) of the data words is kept; it is cleared on entry to HDR.
  - After N words the state goes to CSUM, which expects one more word.
  - Equal to the sum -> RUN; mismatch -> ERR.
  - The trailer is never written to memory.
  - If N==0, CSUM expects 0.
- Without the macro: no CSUM state, and WRITE of the last word -> RUN.

Decomposition:
- Shared package mips_pkg:
  - state enum HDR/DATA/WRITE/CSUM/RUN/ERR
  - ADDR_W, WORD_W=32, DEPTH constants
- One sub-module, word_assembler:
  - Inputs: CLK, RST, CLR, RX_DATA, RX_VALID.
  - Outputs: WORD[31:0], WORD_VALID.

Test Plan:
- Reset, then bytes 00 00 00 02, DE AD BE EF, 12 34 56 78:
  - Writes 0xDEADBEEF@0 and 0x12345678@1.
  - WORDS_LOADED=2; CPU_RST falls 2 cycles after the final byte.
- Header 00 00 00 00: RUN right after the 4th byte, no MEM_WE pulse, CPU_RST=0.
- Header 00 00 00 81 (129 > DEPTH): ERR=1, CPU_RST stays 1, later bytes ignored. LOAD then a valid stream recovers with ERR=0.
- In RUN, drive CPU_ADDR=0x15, CPU_CS=1, CPU_WE=1: MEM_ADDR=0x15, MEM_WE=1 the same cycle, LD_DOE=0.
- LOAD pulsed after 2 of 3 bytes of word 1 (N=3): partial bytes are discarded, state=HDR, CPU_RST=1. A fresh N=1 stream writes @0 only.
- CHECKSUM_EN, N=2, words 1 and 2:
  - Trailer 00 00 00 03 -> RUN.
  - Trailer 00 00 00 04 -> ERR=1, CPU_RST=1.
  - Memory @0/@1 is written in both cases.
